shift_tx: RTL and testbench
===========================

SHIFT_TX -- requirements
Module: shift_tx

Interface
REQ-001 SHALL have parameter: DATA_W, 8, payload bits per frame (legal range 2..32).
REQ-002 SHALL have parameter: IDLE_LEVEL, 1'b1, tx_q level while idle and during the stop bit.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: load_valid  input  1  load_data is valid.
REQ-006 SHALL have port: load_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port: load_data  input  DATA_W  parallel word to serialise.
REQ-008 SHALL have port: tx_q  output  1  registered serial bit stream.
REQ-009 SHALL have port: tx_q_bar  output  1  always the complement of tx_q.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port: done  output  1  one-cycle pulse during the stop bit.

Function
REQ-012 SHALL use FSM states IDLE, START, SHIFT, PARITY, STOP.
REQ-013 SHALL accept a word on a rising edge where load_valid && load_ready; load_data is captured into a shift register on that edge.
REQ-014 SHALL drive load_ready = 1 in IDLE and STOP, and 0 in all other states.
REQ-015 SHALL sequence tx_q after an accept edge E0: the start bit (0) is visible after E0; data bit i (LSB first) is visible after edge E(i+1); the stop bit (IDLE_LEVEL) follows the last data or parity bit for exactly one cycle.
REQ-016 SHALL hold the SHIFT state for exactly DATA_W cycles, with the bit counter running 0..DATA_W-1; the counter is $clog2(DATA_W) bits wide and has no wrap-around beyond DATA_W-1.
REQ-017 SHALL ignore load_data and load_valid while load_ready is 0; the frame in flight is unaffected.
REQ-018 SHALL go STOP -> START with no idle cycle when a word is accepted in STOP (back-to-back); otherwise STOP -> IDLE.
REQ-019 SHALL assert done only in the STOP cycle, including the back-to-back case.
REQ-020 SHALL register tx_q with no combinational path from load_data to tx_q; tx_q_bar SHALL equal ~tx_q at all times, including during reset.

Reset
REQ-021 SHALL, while reset_n = 0, set: state IDLE; tx_q = IDLE_LEVEL; tx_q_bar = ~IDLE_LEVEL; load_ready = 1; busy = 0; done = 0; shift register and counter = 0.
REQ-022 SHALL, on reset assertion mid-frame, abort the frame immediately (asynchronously) with no done pulse; the first accept after reset_n rises starts a fresh frame.

Configuration
REQ-023 SHALL, when PARITY_EN is defined, insert PARITY for one cycle between the last data bit and STOP, driving the even-parity bit (XOR of the captured word); frame = DATA_W+3 cycles.
REQ-024 SHALL, when PARITY_EN is undefined, exclude the PARITY state, go SHIFT -> STOP directly, and use a frame of DATA_W+2 cycles.

Structure
REQ-025 SHALL take the state encoding (enum of the five states) and the default width constant from a shared package shift_tx_pkg.
REQ-026 SHALL implement the output register as one sub-module, dff_r (D flip-flop with async active-low reset, reset value parameter, q/q_bar outputs), instantiated for tx_q/tx_q_bar; the FSM and datapath stay in shift_tx.

Verification
REQ-027 SHALL verify: reset, then load 8'hA5, no PARITY_EN -> tx_q = 0,1,0,1,0,0,1,0,1,1 on consecutive cycles; done high only on the final 1; busy high for 10 cycles.
REQ-028 SHALL verify: PARITY_EN, load 8'h07 -> tx_q = 0,1,1,1,0,0,0,0,0,1(parity),1(stop); 8'hA5 gives a parity bit of 0.
REQ-029 SHALL verify: load_valid held high with 8'h00 then 8'hFF -> second word accepted in the STOP cycle; its start bit immediately follows the stop bit; two done pulses, 10 cycles apart.
REQ-030 SHALL verify: reset_n pulled low at data bit 3 of 8'h3C -> tx_q = 1 and busy = 0 without waiting for clk, no done pulse; a new load of 8'h81 then transmits correctly.
REQ-031 SHALL verify: load_data changed to 8'hFF mid-frame of 8'h12 with load_valid high -> tx_q continues the 8'h12 bits; load_ready stays 0 until STOP.
REQ-032 SHALL verify: tx_q_bar == ~tx_q checked every cycle across all scenarios above.

Source files
------------

// File: rtl/shift_tx_pkg.sv
// Shared definitions for the shift_tx serialiser: FSM state encoding and
// the default payload width.
package shift_tx_pkg;

  // Default payload width in bits.
  localparam int DATA_W_DEFAULT = 8;

  // Frame sequencer states. PARITY is only reachable when the optional
  // parity bit is compiled in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SHIFT  = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

endpackage

// File: rtl/dff_r.sv
// D flip-flop with asynchronous active-low reset to a configurable value.
// Also provides the complement output. The complement is derived directly
// from q, so it stays the exact inverse of q during reset as well.
module dff_r #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic q_bar_o
);

  // Storage element: load d on each rising edge, force RESET_VAL while in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= RESET_VAL;
    end else begin
      q_o <= d_i;
    end
  end

  assign q_bar_o = ~q_o;

endmodule

// File: rtl/shift_tx.sv
// shift_tx: parallel-to-serial frame transmitter.
// Frame: start bit (0), DATA_W data bits LSB first, optional even-parity
// bit, one stop bit (IDLE_LEVEL). A new word may be accepted in the STOP
// cycle, which gives back-to-back frames with no idle gap.
// Optional feature macro: PARITY_EN (adds the PARITY state and bit).
module shift_tx
  import shift_tx_pkg::*;
#(
  parameter int   DATA_W     = DATA_W_DEFAULT,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              tx_q,
  output logic              tx_q_bar,
  output logic              busy,
  output logic              done
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tx_d;
  logic               accept;
`ifdef PARITY_EN
  logic               parity_q, parity_d;
`endif

  assign load_ready = (state_q == IDLE) || (state_q == STOP);
  assign accept     = load_valid && load_ready;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == STOP);

  // Next-state, datapath and next serial bit. tx_d is the bit that becomes
  // visible after the coming edge, so it is chosen by the state being
  // entered; it never depends on load_data directly.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    tx_d     = IDLE_LEVEL;
`ifdef PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE, STOP: begin
        if (accept) begin
          state_d  = START;
          shreg_d  = load_data;
          cnt_d    = '0;
          tx_d     = 1'b0;
`ifdef PARITY_EN
          parity_d = ^load_data;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        // Bit 0 goes out next; pre-shift so bit 1 sits at the LSB.
        state_d = SHIFT;
        cnt_d   = '0;
        tx_d    = shreg_q[0];
        shreg_d = shreg_q >> 1;
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
`ifdef PARITY_EN
          state_d = PARITY;
          tx_d    = parity_q;
`else
          state_d = STOP;
          tx_d    = IDLE_LEVEL;
`endif
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        state_d = STOP;
        tx_d    = IDLE_LEVEL;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`ifdef PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  dff_r #(
    .RESET_VAL (IDLE_LEVEL)
  ) u_tx_reg (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .d_i     (tx_d),
    .q_o     (tx_q),
    .q_bar_o (tx_q_bar)
  );

endmodule

// File: tb/tb_shift_tx.sv
// Directed, table-driven bench for shift_tx (DATA_W = 8, IDLE_LEVEL = 1).
// Expected serial streams are written out by hand in transmit order.
module tb_shift_tx;

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] exp;   // start, d0..d7, stop in transmit order (MSB first)
    logic       par;   // even parity of data
  } vec_t;

`ifdef PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_ready, tx_q, tx_q_bar, busy, done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  vec_t tbl [7];

  shift_tx #(
    .DATA_W     (8),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .tx_q       (tx_q),
    .tx_q_bar   (tx_q_bar),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Complement output checked every cycle, in every scenario.
  always @(negedge clk) begin
    chk("tx_q_bar", {31'd0, tx_q_bar}, {31'd0, ~tx_q});
  end

  function automatic logic exp_bit(input vec_t v, input int k);
`ifdef PARITY_EN
    if (k < 9) return v.exp[9-k];
    else if (k == 9) return v.par;
    else return 1'b1;
`else
    return v.exp[9-k];
`endif
  endfunction

  // Checks one frame cycle by cycle, starting just after the accept edge.
  task automatic check_frame(input vec_t v, input int drop_at, output int done_cyc);
    done_cyc = -1;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      chk($sformatf("tx %02h bit%0d", v.data, k), {31'd0, tx_q}, {31'd0, exp_bit(v, k)});
      chk($sformatf("busy %02h bit%0d", v.data, k), {31'd0, busy}, 32'd1);
      chk($sformatf("done %02h bit%0d", v.data, k), {31'd0, done}, {31'd0, (k == FRAME-1)});
      chk($sformatf("ready %02h bit%0d", v.data, k), {31'd0, load_ready}, {31'd0, (k == FRAME-1)});
      if (done) done_cyc = cyc;
      if (k == drop_at) load_valid = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, " idle tx"}, {31'd0, tx_q}, 32'd1);
    chk({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " idle done"}, {31'd0, done}, 32'd0);
    chk({tag, " idle ready"}, {31'd0, load_ready}, 32'd1);
  endtask

  task automatic send(input vec_t v);
    int d;
    @(negedge clk);
    load_data  = v.data;
    load_valid = 1'b1;
    chk("ready before accept", {31'd0, load_ready}, 32'd1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = ~v.data;
    check_frame(v, -1, d);
    $display("frame %02h sent, done at cycle %0d", v.data, d);
    check_idle($sformatf("after %02h", v.data));
  endtask

  initial begin
    int d1, d2;
    tbl[0] = '{data: 8'hA5, exp: 10'b0101001011, par: 1'b0};
    tbl[1] = '{data: 8'h07, exp: 10'b0111000001, par: 1'b1};
    tbl[2] = '{data: 8'h3C, exp: 10'b0001111001, par: 1'b0};
    tbl[3] = '{data: 8'h81, exp: 10'b0100000011, par: 1'b0};
    tbl[4] = '{data: 8'h00, exp: 10'b0000000001, par: 1'b0};
    tbl[5] = '{data: 8'hFF, exp: 10'b0111111111, par: 1'b0};
    tbl[6] = '{data: 8'h12, exp: 10'b0010010001, par: 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst tx_q", {31'd0, tx_q}, 32'd1);
    chk("rst tx_q_bar", {31'd0, tx_q_bar}, 32'd0);
    chk("rst ready", {31'd0, load_ready}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    check_idle("post reset");

    // Single frames from the table.
    for (int i = 0; i < 5; i++) begin
      send(tbl[i]);
    end

    // Back-to-back: 00 then FF with load_valid held high throughout.
    @(negedge clk);
    load_data  = 8'h00;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_data = 8'hFF;
    check_frame(tbl[4], -1, d1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    check_frame(tbl[5], -1, d2);
    chk("b2b done spacing", d2 - d1, FRAME);
    $display("back-to-back 00/FF, done at cycles %0d and %0d", d1, d2);
    check_idle("after b2b");

    // load_data changes mid-frame while load_valid stays high.
    @(negedge clk);
    load_data  = 8'h12;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_data = 8'hFF;
    check_frame(tbl[6], FRAME-2, d1);
    $display("frame 12 with FF on load_data mid-frame, done at cycle %0d", d1);
    check_idle("after 12");

    // Asynchronous reset at data bit 3 of 3C.
    @(negedge clk);
    load_data  = 8'h3C;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("tx 3C bit%0d", k), {31'd0, tx_q}, {31'd0, exp_bit(tbl[2], k)});
      chk($sformatf("busy 3C bit%0d", k), {31'd0, busy}, 32'd1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("async rst tx_q", {31'd0, tx_q}, 32'd1);
    chk("async rst tx_q_bar", {31'd0, tx_q_bar}, 32'd0);
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst done", {31'd0, done}, 32'd0);
    chk("async rst ready", {31'd0, load_ready}, 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("in rst done", {31'd0, done}, 32'd0);
      chk("in rst busy", {31'd0, busy}, 32'd0);
    end
    reset_n = 1'b1;
    $display("frame 3C aborted by reset at data bit 3");
    check_idle("after abort");
    send(tbl[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
